// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller for the MIPS32 front end. Owns the program
// counter and its PC+4 path, chooses the next PC among sequential, branch,
// jump and exception sources, runs a req/ack instruction-memory handshake and
// presents a one-entry registered IF/ID buffer honouring stalls and flushes.
//
// Parameters
//   RESET_VECTOR    PC loaded on reset
//   EXC_VECTOR      redirect target on exception
//
// Ports
//   clk               clock, all state updates on the rising edge
//   rst               asynchronous active-high reset
//   stall_i           hazard unit: hold IF/ID, accept no new instruction
//   exc_i             exception redirect pulse (highest priority)
//   branch_taken_i    taken-branch redirect pulse
//   branch_target_i   branch target
//   jump_i            jump redirect pulse (lowest priority)
//   jump_target_i     jump target
//   imem_req_o        fetch request
//   imem_addr_o       fetch address, word aligned
//   imem_ack_i        memory completion, rdata valid this cycle
//   imem_rdata_i      fetched instruction
//   if_valid_o        IF/ID entry valid
//   if_pc_o           PC of the IF/ID instruction
//   if_pc4_o          if_pc_o + 4
//   if_instr_o        IF/ID instruction
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        exc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o,
    output logic [31:0] if_instr_o
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [31:0] ALIGN_MASK = ~32'd3;

    state_t      state, state_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] old_addr, old_addr_next;
    logic        pending, pending_next;

    logic        if_valid_next;
    logic [31:0] if_pc_next, if_pc4_next, if_instr_next;

    logic        redirect;
    logic [31:0] raw_target, redirect_target;
    logic        accept;

    // Redirect source selection: exception beats branch beats jump.
    always_comb begin
        redirect = exc_i || branch_taken_i || jump_i;
        if (exc_i) begin
            raw_target = EXC_VECTOR;
        end else if (branch_taken_i) begin
            raw_target = branch_target_i;
        end else begin
            raw_target = jump_target_i;
        end
        redirect_target = raw_target & ALIGN_MASK;
    end

    // Wraps modulo 2^32 naturally.
    assign pc_plus4 = pc_q + 32'd4;

    // Memory-side outputs. pending is a register, so the only combinational
    // inputs to imem_req_o are stall_i, state and if_valid_o. pending keeps
    // an in-flight request raised even if a hold condition appears mid-wait.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        unique case (state)
            BOOT: begin
                imem_req_o = 1'b0;
            end
            FETCH: begin
                imem_req_o = pending || !if_valid_o || !stall_i;
            end
            DISCARD: begin
                imem_req_o  = 1'b1;
                imem_addr_o = old_addr;
            end
            default: begin
                imem_req_o = 1'b0;
            end
        endcase
    end

    // A completed fetch is taken into IF/ID only if the buffer can move
    // (empty or not stalled) and nothing is redirecting the stream.
    assign accept = (state == FETCH) && imem_req_o && imem_ack_i && !redirect &&
                    (!if_valid_o || !stall_i);

    // Next-state and IF/ID update logic.
    always_comb begin
        state_next    = state;
        pc_next       = pc_q;
        old_addr_next = old_addr;
        pending_next  = 1'b0;
        if_valid_next = if_valid_o;
        if_pc_next    = if_pc_o;
        if_pc4_next   = if_pc4_o;
        if_instr_next = if_instr_o;

        unique case (state)
            BOOT: begin
                state_next = FETCH;
                if (redirect) begin
                    pc_next       = redirect_target;
                    if_valid_next = 1'b0;
                end
            end

            FETCH: begin
                if (redirect) begin
                    pc_next       = redirect_target;
                    if_valid_next = 1'b0;
                    // An outstanding request must still be completed at its
                    // original address; its data is thrown away in DISCARD.
                    if (imem_req_o && !imem_ack_i) begin
                        old_addr_next = imem_addr_o;
                        state_next    = DISCARD;
                    end
                end else if (accept) begin
                    if_valid_next = 1'b1;
                    if_pc_next    = pc_q;
                    if_pc4_next   = pc_plus4;
                    if_instr_next = imem_rdata_i;
                    pc_next       = pc_plus4;
                end else begin
                    if (!stall_i) begin
                        if_valid_next = 1'b0;
                    end
                    // Includes an ack that arrived while IF/ID was held:
                    // the request stays up until it can be taken.
                    pending_next = imem_req_o;
                end
            end

            DISCARD: begin
                if (redirect) begin
                    pc_next       = redirect_target;
                    if_valid_next = 1'b0;
                end
                if (imem_ack_i) begin
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc_q       <= RESET_VECTOR & ALIGN_MASK;
            old_addr   <= '0;
            pending    <= 1'b0;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_pc4_o   <= '0;
            if_instr_o <= '0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            old_addr   <= old_addr_next;
            pending    <= pending_next;
            if_valid_o <= if_valid_next;
            if_pc_o    <= if_pc_next;
            if_pc4_o   <= if_pc4_next;
            if_instr_o <= if_instr_next;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Bench for fetch_sequencer. A small instruction memory with programmable
// wait states answers the fetch handshake; a transaction-level model of the
// fetch stream is checked against the DUT every cycle on the falling edge,
// and directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        exc_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;
    logic [31:0] if_instr_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR  (32'h0000_0180)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .exc_i          (exc_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .if_valid_o     (if_valid_o),
        .if_pc_o        (if_pc_o),
        .if_pc4_o       (if_pc4_o),
        .if_instr_o     (if_instr_o)
    );

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: acks after nwait cycles of continuous request.
    int   nwait     = 0;
    int   wcnt      = 0;
    logic force_ack = 1'b0;

    assign imem_ack_i   = force_ack || (imem_req_o && (wcnt >= nwait));
    assign imem_rdata_i = mem(imem_addr_o);

    always @(posedge clk) begin
        if (imem_req_o && !imem_ack_i) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the fetch stream.
    bit          m_boot;
    bit          m_discard;
    bit          m_waiting;
    logic [31:0] m_discard_addr;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_instr;

    always @(negedge clk) begin
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          redir;
        logic [31:0] tgt;
        bit          done;
        if (rst) begin
            chk("rst_req",   32'(imem_req_o), 32'd0);
            chk("rst_valid", 32'(if_valid_o), 32'd0);
            chk("rst_pc",    if_pc_o,    32'd0);
            chk("rst_pc4",   if_pc4_o,   32'd0);
            chk("rst_instr", if_instr_o, 32'd0);
            m_boot     = 1;
            m_discard  = 0;
            m_waiting  = 0;
            m_pc       = 32'h0;
            m_valid    = 0;
            m_if_pc    = 32'h0;
            m_if_instr = 32'h0;
        end else begin
            // What the memory interface must show this cycle.
            if (m_boot) begin
                exp_req  = 0;
                exp_addr = m_pc;
            end else if (m_discard) begin
                exp_req  = 1;
                exp_addr = m_discard_addr;
            end else begin
                // A fetch is wanted unless a held instruction blocks IF/ID,
                // but one already started is never withdrawn.
                exp_req  = m_waiting || !(m_valid && stall_i);
                exp_addr = m_pc;
            end
            chk("req", 32'(imem_req_o), 32'(exp_req));
            if (exp_req) chk("addr", imem_addr_o, exp_addr);
            chk("valid", 32'(if_valid_o), 32'(m_valid));
            if (m_valid) begin
                chk("if_pc",    if_pc_o,    m_if_pc);
                chk("if_pc4",   if_pc4_o,   m_if_pc + 32'd4);
                chk("if_instr", if_instr_o, m_if_instr);
            end

            redir = exc_i || branch_taken_i || jump_i;
            tgt   = exc_i ? 32'h180 : branch_taken_i ? branch_target_i : jump_target_i;
            tgt   = {tgt[31:2], 2'b00};
            done  = exp_req && imem_ack_i;

            if (m_boot) begin
                m_boot = 0;
                if (redir) begin
                    m_pc    = tgt;
                    m_valid = 0;
                end
            end else if (m_discard) begin
                if (redir) m_pc = tgt;
                if (done) m_discard = 0;
            end else if (redir) begin
                m_valid   = 0;
                m_waiting = 0;
                if (exp_req && !done) begin
                    m_discard      = 1;
                    m_discard_addr = m_pc;
                end
                m_pc = tgt;
            end else if (done && !(m_valid && stall_i)) begin
                m_valid    = 1;
                m_if_pc    = m_pc;
                m_if_instr = mem(m_pc);
                m_pc       = m_pc + 32'd4;
                m_waiting  = 0;
            end else begin
                if (!stall_i) m_valid = 0;
                m_waiting = exp_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        rst             = 1'b1;
        stall_i         = 1'b0;
        exc_i           = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'h0;
        jump_i          = 1'b0;
        jump_target_i   = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // First request one cycle after BOOT, zero-wait sequential stream.
        tick(); #1;
        chk("first_req",  32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        tick(); #1;
        chk("seq_pc0",   if_pc_o,  32'h0);
        chk("seq_pc4_0", if_pc4_o, 32'h4);
        chk("seq_addr4", imem_addr_o, 32'h4);
        tick(); tick();

        // Stall with PC 0x8 held; an ack while req is low is ignored.
        stall_i = 1'b1; force_ack = 1'b1; #1;
        chk("stall_pc",    if_pc_o,    32'h8);
        chk("stall_instr", if_instr_o, 32'h135F_6428);
        chk("stall_req",   32'(imem_req_o), 32'd0);
        chk("stall_addr",  imem_addr_o, 32'hC);
        tick(); tick(); #1;
        chk("stall_hold_pc", if_pc_o, 32'h8);
        tick();
        stall_i = 1'b0; force_ack = 1'b0; #1;
        chk("release_addr", imem_addr_o, 32'hC);
        tick();

        // Branch and jump together: branch wins, low bits forced to zero.
        branch_taken_i = 1'b1; branch_target_i = 32'h101;
        jump_i = 1'b1; jump_target_i = 32'h200; #1;
        chk("pre_br_pc", if_pc_o, 32'hC);
        tick();
        branch_taken_i = 1'b0; jump_i = 1'b0; #1;
        chk("br_flush", 32'(if_valid_o), 32'd0);
        chk("br_addr",  imem_addr_o, 32'h100);
        tick();

        // Exception together with a branch: exception vector wins.
        exc_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h100; #1;
        chk("br_pc", if_pc_o, 32'h100);
        tick();
        exc_i = 1'b0; branch_taken_i = 1'b0; #1;
        chk("exc_addr", imem_addr_o, 32'h180);
        tick();

        // Three wait states, redirects during the wait: DISCARD, latest wins.
        nwait = 3; #1;
        chk("exc_pc", if_pc_o, 32'h180);
        tick();
        branch_taken_i = 1'b1; branch_target_i = 32'h40;
        tick();
        branch_taken_i = 1'b0; jump_i = 1'b1; jump_target_i = 32'h60; #1;
        chk("disc_addr", imem_addr_o, 32'h184);
        tick();
        jump_i = 1'b0; #1;
        chk("disc_ack_addr", imem_addr_o, 32'h184);
        tick(); #1;
        chk("after_disc_addr",  imem_addr_o, 32'h60);
        chk("after_disc_valid", 32'(if_valid_o), 32'd0);
        repeat (4) tick();
        #1 chk("wait_pc", if_pc_o, 32'h60);

        // Wrap from 0xFFFF_FFFC to 0.
        nwait = 0; jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFE;
        tick();
        jump_i = 1'b0; #1;
        chk("wrap_addr_hi", imem_addr_o, 32'hFFFF_FFFC);
        tick(); #1;
        chk("wrap_pc",   if_pc_o,     32'hFFFF_FFFC);
        chk("wrap_pc4",  if_pc4_o,    32'h0);
        chk("wrap_addr", imem_addr_o, 32'h0);
        tick();

        // Reset in the middle of a wait; acks during reset/BOOT are ignored.
        nwait = 3;
        tick();
        #2 rst = 1'b1; force_ack = 1'b1; #1;
        chk("async_req",   32'(imem_req_o), 32'd0);
        chk("async_valid", 32'(if_valid_o), 32'd0);
        chk("async_pc",    if_pc_o,    32'h0);
        chk("async_instr", if_instr_o, 32'h0);
        tick(); tick();
        rst = 1'b0; nwait = 0; #1;
        chk("boot_req", 32'(imem_req_o), 32'd0);
        tick();
        force_ack = 1'b0; #1;
        chk("restart_addr", imem_addr_o, 32'h0);
        tick(); #1;
        chk("restart_instr", if_instr_o, 32'h1357_6420);

        // Mixed stalls, redirects and latencies, checked by the model.
        for (int i = 0; i < 60; i++) begin
            v = $urandom;
            stall_i         = (v[1:0] == 2'b00);
            branch_taken_i  = (v[5:2] == 4'h3);
            jump_i          = (v[9:6] == 4'h5);
            exc_i           = (v[15:10] == 6'h11);
            branch_target_i = {16'h0, v[31:16]};
            jump_target_i   = {v[31:16], 16'h0};
            nwait           = (i / 12) % 3;
            tick();
        end
        stall_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0; exc_i = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
